// File: rtl/btn_click_decoder.sv
// -----------------------------------------------------------------------------
// btn_click_decoder
//
// Groups one-cycle button strobes from the debouncer into click gestures.
// Strobes that arrive no more than WINDOW_CYCLES apart belong to one group.
// Each finished group is reported once, with its click count, over a
// valid/ready handshake.
//
// Optional feature macro: BTN_CLICK_HOLDOFF_EN
//   When it is defined, a HOLDOFF lockout of HOLDOFF_CYCLES clocks follows
//   every delivered event. Strobes during the lockout are ignored.
//   When it is not defined, the lockout state and its counter are not built.
//
// Parameters
//   WINDOW_CYCLES   maximum spacing in clocks between strobes of one group
//                   (2..65535)
//   MAX_CLICKS      the group closes as soon as this many clicks are counted
//                   (1..15)
//   HOLDOFF_CYCLES  lockout length after each event; used only with the macro
//                   (1..65535)
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_pulse    in   one-cycle press strobe, synchronous to clk
//   evt_valid    out  an event is available
//   evt_count    out  clicks in the group (1..MAX_CLICKS) while evt_valid
//   evt_dropped  out  a strobe was discarded while this event waited
//   evt_ready    in   the consumer accepts the event
// -----------------------------------------------------------------------------
module btn_click_decoder #(
  parameter int WINDOW_CYCLES  = 1000,
  parameter int MAX_CLICKS     = 3,
  parameter int HOLDOFF_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pulse,
  output logic       evt_valid,
  output logic [3:0] evt_count,
  output logic       evt_dropped,
  input  logic       evt_ready
);

  // Reject illegal parameter values at elaboration time.
  generate
    if (WINDOW_CYCLES < 2 || WINDOW_CYCLES > 65535) begin : g_bad_window
      $error("btn_click_decoder: WINDOW_CYCLES must be in 2..65535");
    end
    if (MAX_CLICKS < 1 || MAX_CLICKS > 15) begin : g_bad_max
      $error("btn_click_decoder: MAX_CLICKS must be in 1..15");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 65535) begin : g_bad_holdoff
      $error("btn_click_decoder: HOLDOFF_CYCLES must be in 1..65535");
    end
  endgenerate

  localparam logic [3:0]  MAX_C    = 4'(MAX_CLICKS);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

`ifdef BTN_CLICK_HOLDOFF_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EMIT    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } state_t;
`endif

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [15:0] timer_reg, timer_next;
  logic        valid_reg, valid_next;
  logic [3:0]  evt_count_reg, evt_count_next;
  logic        dropped_reg, dropped_next;
  logic [3:0]  count_inc;

`ifdef BTN_CLICK_HOLDOFF_EN
  logic [15:0] hold_reg, hold_next;
`endif

  // Saturating increment. MAX_CLICKS=1 can still see a strobe in COUNT after
  // a restart on the handshake edge, and the count must never pass MAX_CLICKS.
  assign count_inc = (count_reg >= MAX_C) ? MAX_C : (count_reg + 4'd1);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    timer_next     = timer_reg;
    valid_next     = valid_reg;
    evt_count_next = evt_count_reg;
    dropped_next   = dropped_reg;
`ifdef BTN_CLICK_HOLDOFF_EN
    hold_next      = hold_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (btn_pulse) begin
          count_next = 4'd1;
          timer_next = 16'd0;
          if (MAX_C == 4'd1) begin
            state_next     = EMIT;
            valid_next     = 1'b1;
            evt_count_next = 4'd1;
          end else begin
            state_next = COUNT;
          end
        end
      end

      COUNT: begin
        // A strobe on the timeout edge is checked first, so it joins the
        // group instead of closing it.
        if (btn_pulse) begin
          count_next = count_inc;
          timer_next = 16'd0;
          if (count_inc == MAX_C) begin
            state_next     = EMIT;
            valid_next     = 1'b1;
            evt_count_next = count_inc;
          end
        end else if (timer_reg == WIN_LAST) begin
          state_next     = EMIT;
          valid_next     = 1'b1;
          evt_count_next = count_reg;
          timer_next     = 16'd0;
        end else begin
          timer_next = timer_reg + 16'd1;
        end
      end

      EMIT: begin
        // evt_valid is always 1 in this state, so evt_ready alone marks the
        // handshake.
        if (evt_ready) begin
          valid_next     = 1'b0;
          evt_count_next = 4'd0;
          dropped_next   = 1'b0;
          count_next     = 4'd0;
          timer_next     = 16'd0;
`ifdef BTN_CLICK_HOLDOFF_EN
          state_next     = HOLDOFF;
          hold_next      = 16'd0;
`else
          // A strobe on the handshake edge opens the next group straight
          // away, so it is not lost.
          if (btn_pulse) begin
            count_next = 4'd1;
            state_next = COUNT;
          end else begin
            state_next = IDLE;
          end
`endif
        end else if (btn_pulse) begin
          dropped_next = 1'b1;
        end
      end

`ifdef BTN_CLICK_HOLDOFF_EN
      HOLDOFF: begin
        // Strobes are ignored here on purpose; they do not set evt_dropped.
        if (hold_reg == HOLD_LAST) begin
          state_next = IDLE;
          hold_next  = 16'd0;
        end else begin
          hold_next = hold_reg + 16'd1;
        end
      end
`endif

      default: begin
        state_next     = IDLE;
        count_next     = 4'd0;
        timer_next     = 16'd0;
        valid_next     = 1'b0;
        evt_count_next = 4'd0;
        dropped_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= 4'd0;
      timer_reg     <= 16'd0;
      valid_reg     <= 1'b0;
      evt_count_reg <= 4'd0;
      dropped_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      timer_reg     <= timer_next;
      valid_reg     <= valid_next;
      evt_count_reg <= evt_count_next;
      dropped_reg   <= dropped_next;
    end
  end

`ifdef BTN_CLICK_HOLDOFF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= 16'd0;
    end else begin
      hold_reg <= hold_next;
    end
  end
`endif

  assign evt_valid   = valid_reg;
  assign evt_count   = evt_count_reg;
  assign evt_dropped = dropped_reg;

endmodule

// File: tb/tb_btn_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_click_decoder
//
// Directed test of btn_click_decoder with WINDOW_CYCLES=8, MAX_CLICKS=3 and
// HOLDOFF_CYCLES=16. Inputs change 1 ns after a rising edge and outputs are
// sampled there, so each step() call covers exactly one sampling edge.
// Expected values are worked out by hand from the edge numbering. The
// observed bus is {evt_valid, evt_count, evt_dropped}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_click_decoder;
  localparam int W = 8;
  localparam int M = 3;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_pulse = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [3:0] evt_count;
  logic       evt_dropped;
  logic [5:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_click_decoder #(
    .WINDOW_CYCLES (W),
    .MAX_CLICKS    (M),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_pulse  (btn_pulse),
    .evt_valid  (evt_valid),
    .evt_count  (evt_count),
    .evt_dropped(evt_dropped),
    .evt_ready  (evt_ready)
  );

  assign obs = {evt_valid, evt_count, evt_dropped};

  // Present p for exactly one sampling edge, then settle 1 ns past it.
  task automatic step(input logic p);
    btn_pulse = p;
    @(posedge clk);
    #1;
    btn_pulse = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL reset_hold got=%b want=%b", obs, 6'b0);
    end
    rst_n = 1'b1;
    step(1'b1); step(1'b0); step(1'b1);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL count_two_quiet got=%b want=%b", obs, 6'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL reset_mid_count got=%b want=%b", obs, 6'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1);
    idle(W - 1);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL reset_pre_timeout got=%b want=%b", obs, 6'b0);
    end
    step(1'b0);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL reset_after_event got=%b want=%b", obs, {1'b1, 4'd1, 1'b0});
    end
    step(1'b0);
    // Close a group at MAX_CLICKS, then reset while the event is pending.
    idle(20);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    total++;
    if (obs !== {1'b1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL reset_pre_emit got=%b want=%b", obs, {1'b1, 4'd3, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL reset_mid_emit got=%b want=%b", obs, 6'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL reset_emit_gone got=%b want=%b", obs, 6'b0);
    end
    idle(20);
    $display("test_reset done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_single;
    step(1'b1);
    idle(W - 1);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL single_early got=%b want=%b", obs, 6'b0);
    end
    step(1'b0);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL single_event got=%b want=%b", obs, {1'b1, 4'd1, 1'b0});
    end
    step(1'b0);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL single_release got=%b want=%b", obs, 6'b0);
    end
    idle(20);
    $display("test_single done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_window_edge;
    // Second pulse exactly W edges after the first joins the group.
    step(1'b1);
    idle(W - 1);
    step(1'b1);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL win8_joined got=%b want=%b", obs, 6'b0);
    end
    idle(W);
    total++;
    if (obs !== {1'b1, 4'd2, 1'b0}) begin
      bad++; $display("FAIL win8_event got=%b want=%b", obs, {1'b1, 4'd2, 1'b0});
    end
    step(1'b0);
    idle(20);
    // Second pulse W+1 edges after the first starts a new group.
    step(1'b1);
    idle(W);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL win9_first got=%b want=%b", obs, {1'b1, 4'd1, 1'b0});
    end
    step(1'b1);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL win9_handshake got=%b want=%b", obs, 6'b0);
    end
    idle(W);
`ifdef BTN_CLICK_HOLDOFF_EN
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL win9_ignored got=%b want=%b", obs, 6'b0);
    end
`else
    total++;
    if (obs !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL win9_second got=%b want=%b", obs, {1'b1, 4'd1, 1'b0});
    end
`endif
    step(1'b0);
    idle(20);
    $display("test_window_edge done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_max_clicks;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL max_early got=%b want=%b", obs, 6'b0);
    end
    step(1'b1);
    total++;
    if (obs !== {1'b1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL max_event got=%b want=%b", obs, {1'b1, 4'd3, 1'b0});
    end
    step(1'b0);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL max_release got=%b want=%b", obs, 6'b0);
    end
    idle(20);
    $display("test_max_clicks done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_backpressure;
    evt_ready = 1'b0;
    step(1'b1);
    idle(W);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL bp_event got=%b want=%b", obs, {1'b1, 4'd1, 1'b0});
    end
    step(1'b1);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b1}) begin
      bad++; $display("FAIL bp_dropped got=%b want=%b", obs, {1'b1, 4'd1, 1'b1});
    end
    idle(3);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b1}) begin
      bad++; $display("FAIL bp_held got=%b want=%b", obs, {1'b1, 4'd1, 1'b1});
    end
    evt_ready = 1'b1;
    step(1'b0);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL bp_handshake got=%b want=%b", obs, 6'b0);
    end
    idle(W + 2);
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL bp_idle got=%b want=%b", obs, 6'b0);
    end
    idle(20);
    $display("test_backpressure done: total=%0d bad=%0d", total, bad);
  endtask

`ifdef BTN_CLICK_HOLDOFF_EN
  task automatic test_holdoff;
    step(1'b1);
    idle(W);
    step(1'b0);                   // handshake edge h
    idle(3);
    step(1'b1);                   // h+4, inside lockout
    idle(10);                     // up to h+14
    total++;
    if (obs !== 6'b0) begin
      bad++; $display("FAIL hold_ignored got=%b want=%b", obs, 6'b0);
    end
    idle(2);                      // h+16
    step(1'b1);                   // h+17, lockout over
    idle(W);
    total++;
    if (obs !== {1'b1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL hold_new_event got=%b want=%b", obs, {1'b1, 4'd1, 1'b0});
    end
    step(1'b0);
    idle(20);
    $display("test_holdoff done: total=%0d bad=%0d", total, bad);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_window_edge();
    test_max_clicks();
    test_backpressure();
`ifdef BTN_CLICK_HOLDOFF_EN
    test_holdoff();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_click_decoder.md
# btn_click_decoder

Downstream consumer of the debounced button stage. Takes the one-cycle `btn_pulse` strobes from the debouncer and groups them into click gestures: pulses spaced no more than `WINDOW_CYCLES` apart form one group. Each finished group is reported as a single event carrying its click count (single, double, triple, …) over a valid/ready handshake to the control logic.

## Interface
- `WINDOW_CYCLES`, default 1000: maximum spacing, in clocks, between pulses of one group; legal range 2..65535.
- `MAX_CLICKS`, default 3: group closes as soon as this many clicks are counted; legal range 1..15.
- `HOLDOFF_CYCLES`, default 500: lockout length after each delivered event; used only with `BTN_CLICK_HOLDOFF_EN`; legal range 1..65535.
- `clk`  in  1  single clock; all logic rises on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_pulse`  in  1  one-cycle press strobe from the debouncer; synchronous to `clk`.
- `evt_valid`  out  1  event available.
- `evt_count`  out  4  clicks in the group, 1..`MAX_CLICKS`; valid while `evt_valid`=1.
- `evt_dropped`  out  1  at least one pulse was discarded while this event waited; valid while `evt_valid`=1.
- `evt_ready`  in  1  consumer accepts the event.

## Operation
- Reset (async assert, sync release): state IDLE; `evt_valid`=0, `evt_count`=0, `evt_dropped`=0; click counter and timer are 0.
- States: IDLE, COUNT, EMIT, and HOLDOFF (HOLDOFF only with the macro).
- IDLE:
  - On `btn_pulse`: counter=1, timer=0.
  - Go to EMIT if `MAX_CLICKS`=1, else go to COUNT.
- COUNT:
  - Timer increments every edge without a pulse.
  - On `btn_pulse`: counter+1 and timer cleared to 0. If the counter now equals `MAX_CLICKS`, go to EMIT.
  - With no pulse and timer==`WINDOW_CYCLES`-1: go to EMIT.
  - A pulse on the same edge as the timeout wins: it is counted and the group continues.
- EMIT:
  - `evt_valid`=1; `evt_count` and `evt_dropped` are held stable until handshake.
  - Handshake occurs on an edge with `evt_valid`&`evt_ready`.
  - Without the macro: handshake goes to IDLE. If `btn_pulse` is high on the handshake edge, it starts a new group (counter=1, go to COUNT).
  - With the macro: handshake goes to HOLDOFF.
  - `btn_pulse` in EMIT without a handshake on that edge is discarded and sets `evt_dropped`=1.
- On handshake: `evt_valid`, `evt_dropped` and `evt_count` return to 0.
- Counter arithmetic is 4-bit and never exceeds `MAX_CLICKS`. Timer width is 16 bits.
- `evt_ready` is ignored when `evt_valid`=0.

## Timing
- All outputs are registered.
- A pulse sampled at edge t joins the group if the previous pulse was sampled at edge t-k, with 1≤k≤`WINDOW_CYCLES`.
- Timeout close: last pulse at edge t, no further pulse → `evt_valid` high after edge t+`WINDOW_CYCLES`.
- Max close: the pulse reaching `MAX_CLICKS` at edge t → `evt_valid` high after edge t.
- `evt_valid` deasserts after the handshake edge. Back-to-back events are impossible; there is at least one COUNT cycle between them.
- Reset mid-group or mid-EMIT: the event in flight is discarded immediately and outputs go to reset values.

## Configuration
- `BTN_CLICK_HOLDOFF_EN` defined:
  - After each handshake the block enters HOLDOFF for `HOLDOFF_CYCLES` clocks, then returns to IDLE.
  - Pulses during HOLDOFF are silently ignored and do not set `evt_dropped`.
  - The pulse-on-handshake-edge restart is disabled.
- Not defined: HOLDOFF state, its counter and `HOLDOFF_CYCLES` are not built; handshake goes straight to IDLE/COUNT as above.

## Test plan
All scenarios use `WINDOW_CYCLES`=8, `MAX_CLICKS`=3, `HOLDOFF_CYCLES`=16, `evt_ready`=1 unless stated.

- Reset: assert `rst_n`=0 mid-COUNT with 2 clicks counted → all outputs 0 immediately. After release, one pulse plus 8 idle cycles → event with `evt_count`=1.
- Single click: pulse at edge 10 → `evt_valid` high after edge 18, `evt_count`=1, `evt_dropped`=0, low after edge 19.
- Window boundary:
  - Pulses at edges 10 and 18 → one event, count=2.
  - Pulses at edges 10 and 19 → two events, count=1 each.
- Max clicks: pulses at edges 10, 12, 14 → `evt_valid` high after edge 14, count=3, no timeout wait.
- Backpressure: `evt_ready`=0, single click, pulse during EMIT → `evt_count`=1, `evt_dropped`=1 held. Raise `evt_ready` → one handshake, then IDLE.
- With `BTN_CLICK_HOLDOFF_EN`: pulse 4 cycles after handshake → no event, `evt_dropped` stays 0. Pulse 17 cycles after handshake → new event, count=1.
